// File: rtl/minimips_mc_ctrl.sv
// Multi-cycle main control FSM for the MiniMIPS datapath (fetch/decode/execute/memory/write-back).
// Optional performance counters are built when MINIMIPS_PERF_CNT_EN is defined.
module minimips_mc_ctrl #(
   parameter int unsigned PC_STEP     = 2,
   parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [2:0]  ALUop,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        i_or_d,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        busy,
   output logic        done,
   output logic        illegal_op
`ifdef MINIMIPS_PERF_CNT_EN
   ,
   output logic [15:0] instr_cnt,
   output logic [15:0] cycle_cnt
`endif
);

   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_BEQ = 4'b0101;

   typedef enum logic [3:0] {
      StIdle, StFetch, StDecode, StExecR, StWbR, StExecI, StWbI,
      StBranch, StMemAddr, StMemRd, StWbMem, StMemWr, StError
   } state_e;

   state_e state_q, state_d;
   logic   done_q, done_d;
   logic   illegal_q, illegal_set;
   logic   instr_end;

   // PC_STEP is realised in the datapath mux; referenced here only for documentation.
   logic unused_pc_step;
   assign unused_pc_step = ^PC_STEP;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         illegal_q <= illegal_q | illegal_set;
      end
   end

   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      illegal_set = 1'b0;
      instr_end   = 1'b0;
      unique case (state_q)
         StIdle:    if (start) state_d = StFetch;
         StFetch:   if (mem_ready) state_d = StDecode;
         StDecode: begin
            if (opcode == HALT_OPCODE) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               case (opcode)
                  4'b0000:                                    state_d = StExecR;
                  4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0111: state_d = StExecI;
                  4'b0101, 4'b0110:                           state_d = StBranch;
                  4'b1000, 4'b1001:                           state_d = StMemAddr;
                  default: begin
                     state_d     = StError;
                     illegal_set = 1'b1;
                  end
               endcase
            end
         end
         StExecR:   state_d = StWbR;
         StExecI:   state_d = StWbI;
         StMemAddr: state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
         StMemRd:   if (mem_ready) state_d = StWbMem;
         StWbR, StWbI, StBranch, StWbMem: begin
            state_d   = StFetch;
            instr_end = 1'b1;
         end
         StMemWr: begin
            if (mem_ready) begin
               state_d   = StFetch;
               instr_end = 1'b1;
            end
         end
         StError:   state_d = StError;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      ALUop         = 3'b000;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      busy          = (state_q != StIdle);
      done          = done_q;
      illegal_op    = illegal_q;
      unique case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         StDecode:  alu_src_b = 2'b10;
         StExecR: begin
            alu_src_a = 1'b1;
            ALUop     = 3'b111;
         end
         StExecI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (opcode)
               4'b0010: ALUop = 3'b001;
               4'b0011: ALUop = 3'b010;
               4'b0100: ALUop = 3'b011;
               4'b0111: ALUop = 3'b101;
               default: ALUop = 3'b000;
            endcase
         end
         StBranch: begin
            alu_src_a     = 1'b1;
            ALUop         = 3'b100;
            // beq taken on zero, bne taken on not-zero
            pc_write_cond = (opcode == OP_BEQ) ? zero : ~zero;
         end
         StMemAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         StMemRd: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         StMemWr: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         StWbR: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         StWbI:     reg_write = 1'b1;
         StWbMem: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef MINIMIPS_PERF_CNT_EN
   logic [15:0] instr_cnt_q, cycle_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_cnt_q <= 16'd0;
         cycle_cnt_q <= 16'd0;
      end else begin
         if (busy)      cycle_cnt_q <= cycle_cnt_q + 16'd1;
         if (instr_end) instr_cnt_q <= instr_cnt_q + 16'd1;
      end
   end

   assign instr_cnt = instr_cnt_q;
   assign cycle_cnt = cycle_cnt_q;
`else
   logic unused_instr_end;
   assign unused_instr_end = instr_end;
`endif

endmodule

// File: tb/tb_minimips_mc_ctrl.sv
// Self-checking bench for minimips_mc_ctrl: instruction vector table plus hand-written corner cases.
module tb_minimips_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  opcode = 4'b0000;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b1;
   logic [2:0]  ALUop;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
   logic        reg_write, reg_dst, mem_to_reg, busy, done, illegal_op;
`ifdef MINIMIPS_PERF_CNT_EN
   logic [15:0] instr_cnt, cycle_cnt;
`endif

   minimips_mc_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .ALUop         (ALUop),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .ir_write      (ir_write),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .i_or_d        (i_or_d),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .busy          (busy),
      .done          (done),
      .illegal_op    (illegal_op)
`ifdef MINIMIPS_PERF_CNT_EN
      ,
      .instr_cnt     (instr_cnt),
      .cycle_cnt     (cycle_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic        z;
      int          n;
      logic [17:0] seq [6];
   } vec_t;

   vec_t        vecs[$];
   logic [17:0] expq[$];
   string       nameq[$];
   int          total = 0;
   int          bad = 0;

   logic [17:0] act;
   assign act = {ALUop, alu_src_a, alu_src_b, pc_write, pc_write_cond, ir_write, mem_read,
                 mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, busy, done, illegal_op};

   function automatic logic [17:0] w(input logic [2:0] aop, input logic a, input logic [1:0] b,
                                     input logic pcw, input logic pcwc, input logic irw,
                                     input logic mr, input logic mw, input logic iord,
                                     input logic rw, input logic rdst, input logic m2r,
                                     input logic bsy, input logic dn, input logic ill);
      return {aop, a, b, pcw, pcwc, irw, mr, mw, iord, rw, rdst, m2r, bsy, dn, ill};
   endfunction

   logic [17:0] f1, f0, dec, xr, wr, wi, br0, br1, ma, mrd, wbm, mwr, idn, idl, err, zw;
   logic [17:0] xi [8];

   task automatic check(input string nm, input logic [17:0] a, input logic [17:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, a, e);
      end
   endtask

   task automatic push(input string nm, input logic [17:0] e);
      nameq.push_back(nm);
      expq.push_back(e);
   endtask

   task automatic step(input logic mr);
      @(negedge clk);
      mem_ready = mr;
      #1;
      if (expq.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
         check(nameq.pop_front(), act, expq.pop_front());
      end
   endtask

   task automatic ps(input string nm, input logic [17:0] e, input logic mr);
      push(nm, e);
      step(mr);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      mem_ready = 1'b1;
      zero = 1'b0;
      @(negedge clk);
      #1;
      check("reset_outputs", act, zw);
`ifdef MINIMIPS_PERF_CNT_EN
      check("reset_cnt", {2'b00, instr_cnt}, 18'd0);
      check("reset_cyc", {2'b00, cycle_cnt}, 18'd0);
`endif
      rst_n = 1'b1;
   endtask

   task automatic kick(input logic [3:0] op, input logic z);
      opcode = op;
      zero = z;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic addv(input logic [3:0] op, input logic z, input int n,
                       input logic [17:0] s0, input logic [17:0] s1, input logic [17:0] s2,
                       input logic [17:0] s3, input logic [17:0] s4, input logic [17:0] s5);
      vec_t v;
      v.op = op;
      v.z = z;
      v.n = n;
      v.seq = '{s0, s1, s2, s3, s4, s5};
      vecs.push_back(v);
   endtask

   initial begin
      zw  = 18'd0;
      f1  = w(3'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      f0  = w(3'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      dec = w(3'd0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      xr  = w(3'd7, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      wr  = w(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      wi  = w(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      br0 = w(3'd4, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      br1 = w(3'd4, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      ma  = w(3'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      mrd = w(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      wbm = w(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      mwr = w(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idn = w(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idl = zw;
      err = w(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++)
         xi[k] = w(3'(k), 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b1, 1'b0, 1'b0);

      // Per-cycle expected outputs from the first FETCH, mem_ready held high
      addv(4'b0000, 1'b0, 5, f1, dec, xr,     wr,  f1,  zw);
      addv(4'b0001, 1'b0, 5, f1, dec, xi[0],  wi,  f1,  zw);
      addv(4'b0010, 1'b0, 5, f1, dec, xi[1],  wi,  f1,  zw);
      addv(4'b0011, 1'b0, 5, f1, dec, xi[2],  wi,  f1,  zw);
      addv(4'b0100, 1'b0, 5, f1, dec, xi[3],  wi,  f1,  zw);
      addv(4'b0111, 1'b0, 5, f1, dec, xi[5],  wi,  f1,  zw);
      addv(4'b0101, 1'b1, 4, f1, dec, br1,    f1,  zw,  zw);
      addv(4'b0101, 1'b0, 4, f1, dec, br0,    f1,  zw,  zw);
      addv(4'b0110, 1'b0, 4, f1, dec, br1,    f1,  zw,  zw);
      addv(4'b0110, 1'b1, 4, f1, dec, br0,    f1,  zw,  zw);
      addv(4'b1000, 1'b0, 6, f1, dec, ma,     mrd, wbm, f1);
      addv(4'b1001, 1'b0, 5, f1, dec, ma,     mwr, f1,  zw);
      addv(4'b1111, 1'b0, 4, f1, dec, idn,    idl, zw,  zw);
      addv(4'b1010, 1'b0, 4, f1, dec, err,    err, zw,  zw);
      addv(4'b1100, 1'b0, 3, f1, dec, err,    zw,  zw,  zw);

      for (int i = 0; i < vecs.size(); i++) begin
         do_reset();
         kick(vecs[i].op, vecs[i].z);
         for (int k = 0; k < vecs[i].n; k++)
            push($sformatf("vec%0d_op%b_cyc%0d", i, vecs[i].op, k), vecs[i].seq[k]);
         for (int k = 0; k < vecs[i].n; k++)
            step(1'b1);
      end

      // lw with a FETCH stall and three MEM_RD wait cycles
      do_reset();
      kick(4'b1000, 1'b0);
      ps("lw_fetch_wait", f0, 1'b0);
      ps("lw_fetch", f1, 1'b1);
      ps("lw_decode", dec, 1'b1);
      ps("lw_addr", ma, 1'b1);
      for (int k = 0; k < 3; k++) ps($sformatf("lw_rd_wait%0d", k), mrd, 1'b0);
      ps("lw_rd_ready", mrd, 1'b1);
      ps("lw_wb", wbm, 1'b1);
      ps("lw_next_fetch", f1, 1'b1);

      // start and mem_ready are ignored outside IDLE / memory states
      do_reset();
      kick(4'b0000, 1'b0);
      ps("r_fetch", f1, 1'b1);
      start = 1'b1;
      ps("r_decode_noready", dec, 1'b0);
      ps("r_exec_noready", xr, 1'b0);
      ps("r_wb_noready", wr, 1'b0);
      ps("r_next_fetch", f1, 1'b1);
      start = 1'b0;
`ifdef MINIMIPS_PERF_CNT_EN
      check("perf_cycle_cnt", {2'b00, cycle_cnt}, 18'd4);
      check("perf_instr_cnt", {2'b00, instr_cnt}, 18'd1);
`endif

      // HALT then restart from IDLE
      do_reset();
      kick(4'b1111, 1'b0);
      ps("halt_fetch", f1, 1'b1);
      ps("halt_decode", dec, 1'b1);
      ps("halt_done", idn, 1'b1);
      ps("halt_idle", idl, 1'b1);
      kick(4'b0000, 1'b0);
      ps("restart_fetch", f1, 1'b1);

      // asynchronous reset while MEM_WR is waiting
      do_reset();
      kick(4'b1001, 1'b0);
      ps("sw_fetch", f1, 1'b1);
      ps("sw_decode", dec, 1'b1);
      ps("sw_addr", ma, 1'b1);
      ps("sw_wr_wait0", mwr, 1'b0);
      ps("sw_wr_wait1", mwr, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_mid_write", act, zw);
`ifdef MINIMIPS_PERF_CNT_EN
      check("async_reset_instr_cnt", {2'b00, instr_cnt}, 18'd0);
      check("async_reset_cycle_cnt", {2'b00, cycle_cnt}, 18'd0);
`endif
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
